// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues in-order requests to a variable-latency
// instruction memory, and buffers returned words for the IF/ID register.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned           FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  StallF,
  input  logic                  BranchTaken,
  input  logic [ADDR_WIDTH-1:0] BranchTarget,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_valid,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           InstrF,
  output logic                  InstrValidF,
  output logic [ADDR_WIDTH-1:0] PCF,
  output logic [ADDR_WIDTH-1:0] PCPlus4F
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] SLOT_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [31:0]           fifo_instr_q [FIFO_DEPTH];
  logic [31:0]           fifo_instr_d [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_q    [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_d    [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] tag_pc_q     [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] tag_pc_d     [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      tag_rd_ptr_q, tag_rd_ptr_d;
  logic [PTR_W-1:0]      tag_wr_ptr_q, tag_wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;
  logic [CNT_W-1:0]      discard_q, discard_d;

  logic [CNT_W:0]        used_slots;
  logic                  push;
  logic                  pop;

  // Credit counts buffered entries plus in-flight requests, so every
  // response is guaranteed a free FIFO slot.
  assign used_slots  = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem_req    = reset & ~BranchTaken & (used_slots < SLOT_LIMIT);
  assign imem_addr   = fetch_pc_q;
  assign InstrValidF = (count_q != '0);
  assign InstrF      = InstrValidF ? fifo_instr_q[rd_ptr_q] : 32'h0;
  assign PCF         = InstrValidF ? fifo_pc_q[rd_ptr_q] : RESET_PC;
  assign PCPlus4F    = PCF + PC_STEP;

  assign push = imem_valid & (discard_q == '0) & ~BranchTaken;
  assign pop  = InstrValidF & ~StallF;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    fifo_instr_d  = fifo_instr_q;
    fifo_pc_d     = fifo_pc_q;
    tag_pc_d      = tag_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    tag_rd_ptr_d  = tag_rd_ptr_q;
    tag_wr_ptr_d  = tag_wr_ptr_q;
    count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
    outstanding_d = outstanding_q + CNT_W'(imem_req) - CNT_W'(imem_valid);
    discard_d     = discard_q;

    if (imem_req) begin
      fetch_pc_d             = fetch_pc_q + PC_STEP;
      tag_pc_d[tag_wr_ptr_q] = fetch_pc_q;
      tag_wr_ptr_d           = tag_wr_ptr_q + PTR_W'(1);
    end

    // Every response retires its tag, whether it is kept or dropped.
    if (imem_valid) begin
      tag_rd_ptr_d = tag_rd_ptr_q + PTR_W'(1);
      if (discard_q != '0) discard_d = discard_q - CNT_W'(1);
    end

    if (push) begin
      fifo_instr_d[wr_ptr_q] = imem_rdata;
      fifo_pc_d[wr_ptr_q]    = tag_pc_q[tag_rd_ptr_q];
      wr_ptr_d               = wr_ptr_q + PTR_W'(1);
    end

    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (BranchTaken) begin
      fetch_pc_d = BranchTarget & ALIGN_MASK;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      discard_d  = outstanding_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      tag_rd_ptr_q  <= '0;
      tag_wr_ptr_q  <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      tag_rd_ptr_q  <= tag_rd_ptr_d;
      tag_wr_ptr_q  <= tag_wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_instr_q <= fifo_instr_d;
    fifo_pc_q    <= fifo_pc_d;
    tag_pc_q     <= tag_pc_d;
  end

  // A response with nothing outstanding means the memory broke protocol.
  resp_has_request: assert property (
    @(posedge clk) disable iff (!reset) imem_valid |-> (outstanding_q != '0)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector tables with an in-order fixed-latency
// memory model, plus hand sequences for mid-run reset and PC wrap.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, StallF, BranchTaken;
  logic [31:0] BranchTarget;
  logic        imem_req, imem_valid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] InstrF, PCF, PCPlus4F;
  logic        InstrValidF;

  logic        w_reset, w_stall, w_br, w_valid;
  logic [31:0] w_tgt, w_rdata;
  logic        w_req, w_instr_valid;
  logic [31:0] w_addr, w_instr, w_pcf, w_pcplus4;

  fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .InstrF(InstrF),
    .InstrValidF(InstrValidF), .PCF(PCF), .PCPlus4F(PCPlus4F)
  );

  fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_w (
    .clk(clk), .reset(w_reset), .StallF(w_stall), .BranchTaken(w_br),
    .BranchTarget(w_tgt), .imem_req(w_req), .imem_addr(w_addr),
    .imem_valid(w_valid), .imem_rdata(w_rdata), .InstrF(w_instr),
    .InstrValidF(w_instr_valid), .PCF(w_pcf), .PCPlus4F(w_pcplus4)
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] instr;
    logic [31:0] pcf;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;

  mem_t pend[$];
  int   cyc;
  int   lat;
  int   n_checks;
  int   n_pass;
  vec_t stream_v[15];
  vec_t br_v[19];

  function automatic vec_t mk(logic stall, logic br, logic [31:0] tgt, logic req,
                              logic [31:0] addr, logic vld, logic [31:0] instr,
                              logic [31:0] pcf);
    vec_t v;
    v.stall = stall; v.br = br; v.tgt = tgt; v.req = req;
    v.addr = addr; v.vld = vld; v.instr = instr; v.pcf = pcf;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive_mem();
    mem_t m;
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      m = pend.pop_front();
      imem_valid = 1'b1;
      imem_rdata = 32'h100 + m.addr;
    end
  endtask

  task automatic tick();
    mem_t m;
    if (!reset) pend.delete();
    else if (imem_req) begin
      m.addr = imem_addr;
      m.due  = cyc + lat;
      pend.push_back(m);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    drive_mem();
  endtask

  task automatic apply(vec_t v, string tag);
    StallF       = v.stall;
    BranchTaken  = v.br;
    BranchTarget = v.tgt;
    #1;
    check({tag, ".req"}, 32'(imem_req), 32'(v.req));
    if (v.req) check({tag, ".addr"}, imem_addr, v.addr);
    check({tag, ".valid"}, 32'(InstrValidF), 32'(v.vld));
    check({tag, ".instr"}, InstrF, v.instr);
    if (v.vld) begin
      check({tag, ".pcf"}, PCF, v.pcf);
      check({tag, ".pcplus4"}, PCPlus4F, v.pcf + 32'h4);
    end
    tick();
  endtask

  initial begin
    reset = 1'b0; StallF = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'h0;
    imem_valid = 1'b0; imem_rdata = 32'h0;
    w_reset = 1'b0; w_stall = 1'b0; w_br = 1'b0; w_tgt = 32'h0;
    w_valid = 1'b0; w_rdata = 32'h0;
    cyc = 0; lat = 1; n_checks = 0; n_pass = 0;

    // 1-cycle memory: streaming, then a 5-cycle stall with head PC 0x8
    stream_v[0]  = mk(0, 0, 0, 1, 32'h00, 0, 32'h0,   32'h0);
    stream_v[1]  = mk(0, 0, 0, 1, 32'h04, 0, 32'h0,   32'h0);
    stream_v[2]  = mk(0, 0, 0, 1, 32'h08, 1, 32'h100, 32'h00);
    stream_v[3]  = mk(0, 0, 0, 1, 32'h0C, 1, 32'h104, 32'h04);
    stream_v[4]  = mk(1, 0, 0, 1, 32'h10, 1, 32'h108, 32'h08);
    stream_v[5]  = mk(1, 0, 0, 1, 32'h14, 1, 32'h108, 32'h08);
    stream_v[6]  = mk(1, 0, 0, 0, 32'h0,  1, 32'h108, 32'h08);
    stream_v[7]  = mk(1, 0, 0, 0, 32'h0,  1, 32'h108, 32'h08);
    stream_v[8]  = mk(1, 0, 0, 0, 32'h0,  1, 32'h108, 32'h08);
    stream_v[9]  = mk(0, 0, 0, 0, 32'h0,  1, 32'h108, 32'h08);
    stream_v[10] = mk(0, 0, 0, 1, 32'h18, 1, 32'h10C, 32'h0C);
    stream_v[11] = mk(0, 0, 0, 1, 32'h1C, 1, 32'h110, 32'h10);
    stream_v[12] = mk(0, 0, 0, 1, 32'h20, 1, 32'h114, 32'h14);
    stream_v[13] = mk(0, 0, 0, 1, 32'h24, 1, 32'h118, 32'h18);
    stream_v[14] = mk(0, 0, 0, 1, 32'h28, 1, 32'h11C, 32'h1C);

    // 3-cycle memory: redirect with two in flight, later branch+stall+response
    br_v[0]  = mk(0, 0, 0,        1, 32'h00,  0, 32'h0,   32'h0);
    br_v[1]  = mk(0, 0, 0,        1, 32'h04,  0, 32'h0,   32'h0);
    br_v[2]  = mk(0, 1, 32'h43,   0, 32'h0,   0, 32'h0,   32'h0);
    br_v[3]  = mk(0, 0, 0,        1, 32'h40,  0, 32'h0,   32'h0);
    br_v[4]  = mk(0, 0, 0,        1, 32'h44,  0, 32'h0,   32'h0);
    br_v[5]  = mk(0, 0, 0,        1, 32'h48,  0, 32'h0,   32'h0);
    br_v[6]  = mk(0, 0, 0,        1, 32'h4C,  0, 32'h0,   32'h0);
    br_v[7]  = mk(0, 0, 0,        0, 32'h0,   1, 32'h140, 32'h40);
    br_v[8]  = mk(0, 0, 0,        1, 32'h50,  1, 32'h144, 32'h44);
    br_v[9]  = mk(0, 0, 0,        1, 32'h54,  1, 32'h148, 32'h48);
    br_v[10] = mk(0, 0, 0,        1, 32'h58,  1, 32'h14C, 32'h4C);
    br_v[11] = mk(0, 0, 0,        1, 32'h5C,  0, 32'h0,   32'h0);
    br_v[12] = mk(1, 1, 32'h200,  0, 32'h0,   1, 32'h150, 32'h50);
    br_v[13] = mk(0, 0, 0,        1, 32'h200, 0, 32'h0,   32'h0);
    br_v[14] = mk(0, 0, 0,        1, 32'h204, 0, 32'h0,   32'h0);
    br_v[15] = mk(0, 0, 0,        1, 32'h208, 0, 32'h0,   32'h0);
    br_v[16] = mk(0, 0, 0,        1, 32'h20C, 0, 32'h0,   32'h0);
    br_v[17] = mk(0, 0, 0,        0, 32'h0,   1, 32'h300, 32'h200);
    br_v[18] = mk(0, 0, 0,        1, 32'h210, 1, 32'h304, 32'h204);

    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("rst[%0d].req", i),   32'(imem_req),    32'h0);
      check($sformatf("rst[%0d].valid", i), 32'(InstrValidF), 32'h0);
      check($sformatf("rst[%0d].instr", i), InstrF,           32'h0);
      check($sformatf("rst[%0d].pcf", i),   PCF,              32'h0);
      tick();
    end

    reset = 1'b1;
    for (int i = 0; i < 15; i++) apply(stream_v[i], $sformatf("stream[%0d]", i));

    // Reset in the middle of a stream, with a response on the wire
    reset = 1'b0;
    #1;
    tick();
    #1;
    check("midrst.req",     32'(imem_req),    32'h0);
    check("midrst.valid",   32'(InstrValidF), 32'h0);
    check("midrst.instr",   InstrF,           32'h0);
    check("midrst.pcf",     PCF,              32'h0);
    check("midrst.pcplus4", PCPlus4F,         32'h4);

    reset = 1'b1;
    lat = 3;
    for (int i = 0; i < 19; i++) apply(br_v[i], $sformatf("branch[%0d]", i));

    // PC wrap on the second instance; main instance parked in reset
    reset = 1'b0;
    StallF = 1'b0; BranchTaken = 1'b0;
    #1;
    check("wrap.rst.req",     32'(w_req),         32'h0);
    check("wrap.rst.valid",   32'(w_instr_valid), 32'h0);
    check("wrap.rst.pcf",     w_pcf,              32'hFFFF_FFF8);
    check("wrap.rst.pcplus4", w_pcplus4,          32'hFFFF_FFFC);
    w_reset = 1'b1;
    #1;
    check("wrap0.addr", w_addr, 32'hFFFF_FFF8);
    tick();
    w_valid = 1'b1; w_rdata = 32'hAAAA_0000;
    #1;
    check("wrap1.addr", w_addr, 32'hFFFF_FFFC);
    tick();
    w_valid = 1'b1; w_rdata = 32'hBBBB_0000;
    #1;
    check("wrap2.req",     32'(w_req),         32'h1);
    check("wrap2.addr",    w_addr,             32'h0000_0000);
    check("wrap2.valid",   32'(w_instr_valid), 32'h1);
    check("wrap2.instr",   w_instr,            32'hAAAA_0000);
    check("wrap2.pcf",     w_pcf,              32'hFFFF_FFF8);
    check("wrap2.pcplus4", w_pcplus4,          32'hFFFF_FFFC);
    tick();
    w_valid = 1'b0; w_rdata = 32'h0;
    #1;
    check("wrap3.addr",    w_addr,             32'h0000_0004);
    check("wrap3.valid",   32'(w_instr_valid), 32'h1);
    check("wrap3.instr",   w_instr,            32'hBBBB_0000);
    check("wrap3.pcf",     w_pcf,              32'hFFFF_FFFC);
    check("wrap3.pcplus4", w_pcplus4,          32'h0000_0000);
    tick();
    w_reset = 1'b0;
    #1;
    tick();
    #1;
    check("wrap.end.valid", 32'(w_instr_valid), 32'h0);
    check("wrap.end.pcf",   w_pcf,              32'hFFFF_FFF8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Pipeline fetch stage sitting directly upstream of the IF/ID segment register.
- Owns the program counter and issues in-order requests to a variable-latency instruction memory.
- Buffers returned words in a small FIFO and presents InstrF/PCF/PCPlus4F to the datapath.
- Handles stall and branch redirect, discarding in-flight responses fetched down the wrong path.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 4, instruction buffer entries; also the cap on entries plus outstanding requests (power of two, >=2).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- StallF  in  1  hold the presented instruction (hazard unit).
- BranchTaken  in  1  redirect fetch this cycle.
- BranchTarget  in  ADDR_WIDTH  redirect address; bits [1:0] forced to 0.
- imem_req  out  1  request valid; memory always accepts in the same cycle.
- imem_addr  out  ADDR_WIDTH  request address (word aligned).
- imem_valid  in  1  response valid; responses return in order, >=1 cycle after request.
- imem_rdata  in  32  response word.
- InstrF  out  32  instruction at FIFO head; 32'h0 (bubble) when empty.
- InstrValidF  out  1  FIFO non-empty.
- PCF  out  ADDR_WIDTH  PC of head entry; RESET_PC when empty after reset.
- PCPlus4F  out  ADDR_WIDTH  PCF+4, wraps modulo 2^ADDR_WIDTH.

Behaviour:
- Reset (reset==0 at a rising edge):
  - fetch PC <= RESET_PC; FIFO emptied; outstanding and discard counters <= 0.
  - Outputs: imem_req=0, InstrF=0, InstrValidF=0, PCF=RESET_PC.
  - Reset mid-operation abandons all in-flight requests; responses arriving after reset are ignored only up to the discard count, which is 0, so memory must also be reset.
- Request issue, combinational from registered state:
  - imem_req=1 when reset==1, BranchTaken==0 and (fifo_count + outstanding) < FIFO_DEPTH. Registered counts only; there is no bypass of a same-cycle pop.
  - imem_addr = fetch PC. On issue: fetch PC <= fetch PC+4, outstanding++.
- Response:
  - imem_valid decrements outstanding.
  - If discard>0: discard--, word dropped.
  - Else: push {imem_rdata, PC} to FIFO. The tag PC comes from a parallel in-order PC queue written at issue.
- Pop: head popped when InstrValidF==1 and StallF==0. Push and pop in the same cycle are both honoured; count is unchanged.
- Stall: StallF==1 holds InstrF/PCF. Fetch continues until the credit limit, then imem_req drops.
- Redirect (BranchTaken==1), highest priority:
  - FIFO flushed.
  - discard <= outstanding (after this cycle's response decrement).
  - fetch PC <= {BranchTarget[ADDR_WIDTH-1:2],2'b00}.
  - imem_req=0 this cycle.
  - The next cycle issues to the target.
  - Any response in the redirect cycle is discarded.
  - Overrides StallF.
- Latency: 1-cycle memory gives first InstrValidF two cycles after the first request. Steady state is 1 instruction/cycle with FIFO_DEPTH>=3.
- Counters are saturation-free by construction: outstanding <= FIFO_DEPTH, discard <= FIFO_DEPTH. A response with outstanding==0 is a protocol error; assert in simulation.
- Fetch PC wraps modulo 2^ADDR_WIDTH.

Test Plan:
- Reset: hold reset=0 for 3 cycles -> imem_req=0, InstrValidF=0, InstrF=0, PCF=0. Release -> first cycle imem_req=1, imem_addr=0x0.
- Streaming: 1-cycle memory returning 0x100+addr -> InstrValidF rises 2 cycles after release. Then InstrF=0x100,0x104,0x108... one per cycle with PCF=0,4,8 and PCPlus4F=PCF+4.
- Stall: StallF=1 for 5 cycles while head PCF=0x8 -> InstrF/PCF constant. Requests stop once entries+outstanding=4. On release, 0xC and onward follow with no gap or duplicate.
- Branch with in-flight: 3-cycle memory, 2 outstanding, BranchTaken=1 with BranchTarget=0x43 -> both stale responses dropped. Next request addr=0x40. First valid PCF=0x40 and no stale word ever visible.
- Simultaneous: BranchTaken, StallF and imem_valid all asserted in one cycle -> FIFO empty next cycle, response discarded, imem_req=0 that cycle.
- Wrap and reset mid-run: RESET_PC=0xFFFF_FFF8 -> addrs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. Asserting reset mid-stream returns all outputs to reset values on the next edge.
